// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle sequencer feeding an 8-bit combinational ALU from a private 4x8 register file
// Ports: clk, rst (sync, active-high); instr/instr_valid/instr_ready instruction handshake;
//   alu_in1/alu_in2/alu_op registered ALU operands, alu_out/alu_flags ALU result (CZNV);
//   flags architectural CZNV register; done/err one-cycle retire pulse; dbg_sel/dbg_data rf peek.
//   Define ALU_SEQ_LDI_EN to make op 15 load rd with imm; otherwise op 15 is illegal.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic        done,
  output logic        err,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RETIRE} state_t;
  state_t state, state_nx;
  logic [7:0] rf [4];
  logic [3:0] op;
  logic [1:0] rd;
  logic [7:0] imm, res;
  logic [3:0] res_flags;
  function automatic logic is_alu(input logic [3:0] o);
    return o <= 4'd4 || o == 4'd11;
  endfunction
  function automatic logic is_ldi(input logic [3:0] o);
`ifdef ALU_SEQ_LDI_EN
    return o == 4'd15;
`else
    return o == 4'd15 && 1'b0;
`endif
  endfunction
  // Illegal ops and LDI bypass the ALU and go straight to RETIRE.
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE    ? (instr_valid ? (is_alu(instr[15:12]) ? ISSUE : RETIRE) : IDLE) :
               state == ISSUE   ? CAPTURE :
               state == CAPTURE ? RETIRE : IDLE;
  end
  assign instr_ready = state == IDLE && !rst;
  assign done = state == RETIRE && !rst;
  assign err = done && !is_alu(op) && !is_ldi(op);
  assign dbg_data = rf[dbg_sel];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rf <= '{default: '0};
      flags <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_op <= '0;
      op <= '0;
      rd <= '0;
      imm <= '0;
      res <= '0;
      res_flags <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && instr_valid) begin
        op <= instr[15:12];
        rd <= instr[11:10];
        imm <= instr[7:0];
        // Operands are sampled here, so rd aliasing rs/rt reads the old value.
        if (is_alu(instr[15:12])) begin
          alu_op <= instr[15:12];
          alu_in1 <= rf[instr[9:8]];
          alu_in2 <= instr[15:12] == 4'd11 ? 8'h00 : rf[instr[7:6]];
        end
      end
      if (state == CAPTURE) begin
        res <= alu_out;
        res_flags <= alu_flags;
      end
      if (state == RETIRE && (is_alu(op) || is_ldi(op))) rf[rd] <= is_ldi(op) ? imm : res;
      // Only ADD produces a meaningful carry; other ALU ops keep the previous one.
      if (state == RETIRE && is_alu(op)) flags <= op == 4'd0 ? res_flags : {flags[3], res_flags[2:0]};
    end
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer that drives the 8-bit combinational ALU from the initiator side. It accepts one 16-bit instruction per handshake and reads operands from a private 4×8-bit register file. It presents `in1`/`in2`/`ALU_OP` to the ALU, captures its `out`/`flags` a cycle later, and writes the result and flags back. It sits between the instruction source (test harness or fetch unit) and the ALU datapath.

## Interface
- No parameters; widths are fixed by the ALU (8-bit data, 4-bit op, 4-bit flags).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instr` input 16: instruction; [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [7:0] imm (LDI only).
- `instr_valid` input 1: instruction present.
- `instr_ready` output 1: sequencer can accept an instruction (IDLE only).
- `alu_in1` output 8: ALU operand 1 (registered).
- `alu_in2` output 8: ALU operand 2 (registered).
- `alu_op` output 4: ALU opcode (registered).
- `alu_out` input 8: ALU result.
- `alu_flags` input 4: ALU flags; [3] carry, [2] zero, [1] negative, [0] overflow.
- `flags` output 4: architectural flags register.
- `done` output 1: one-cycle pulse when an instruction retires.
- `err` output 1: with `done`, marks an illegal opcode.
- `dbg_sel` input 2: register-file read select.
- `dbg_data` output 8: combinational read of `rf[dbg_sel]`.

## Operation
- Legal ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 11 NOT (unary: `alu_in2` driven 0).
- Op 15 is LDI when enabled (see Configuration). Ops 5–10, 12–14 are illegal.
- FSM: IDLE → ISSUE → CAPTURE → RETIRE → IDLE.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, latch `instr` and go to ISSUE.
- ISSUE: drive `alu_in1`=`rf[rs]`, `alu_in2`=`rf[rt]`, `alu_op`=op. These are registered on entry and held until the next ISSUE.
- CAPTURE: sample `alu_out` and `alu_flags` into result registers at the end of the cycle.
- RETIRE: write the result to `rf[rd]`, update `flags`, and assert `done` for this cycle only.
- Flag update rules:
  - ADD updates all four flags.
  - Other legal ALU ops update [2:0] and keep [3] (carry) unchanged.
- Illegal op:
  - Skips ISSUE/CAPTURE: IDLE → RETIRE directly.
  - `done`=1 and `err`=1; no register-file write; `flags` unchanged; `alu_*` outputs unchanged.
- LDI: IDLE → RETIRE, writing `rf[rd]`=imm. Flags are untouched and `err`=0.
- `rd` equal to `rs` or `rt` is allowed. Operands are already registered in ISSUE, so the old value is used.
- Reset:
  - `rf` is all 0, `flags`=0, `alu_in1`/`alu_in2`/`alu_op`=0, `done`=0, `err`=0, state IDLE.
  - `instr_ready` is 0 while `rst` is high and 1 on the first cycle after.
  - Reset mid-instruction aborts it: no write-back, no `done`.

## Timing
- Accept at edge N (state becomes ISSUE). ALU operands are valid from cycle N+1.
- Capture occurs at edge N+2. `done` is high during cycle N+3, and `rf`/`flags` are visible from N+4.
- ALU instruction latency: 3 cycles from accept to `done`. Throughput is one instruction per 4 cycles.
- Illegal and LDI: `done` in cycle N+1. Throughput is one per 2 cycles.
- `instr_valid` asserted outside IDLE is ignored. The source must hold `instr` stable until ready.
- The ALU combinational path must settle within one cycle; no multicycle path is assumed.

## Configuration
- `ALU_SEQ_LDI_EN` defined: op 15 is LDI as described above.
- `ALU_SEQ_LDI_EN` undefined: op 15 is illegal (`err`=1, no write). This is the only way to load data, so benches without it preload via reset values only.

## Test plan
- Reset, then LDI r0←0x7F, LDI r1←0x01, ADD r2=r0+r1 → `rf[2]`=0x80, `flags`=4'b0011 (no carry, non-zero, negative, overflow), `done` exactly 3 cycles after the ADD accept.
- LDI r0←0xFF, LDI r1←0x01, ADD r3=r0+r1, then AND r3=r0&r1:
  - After ADD: `rf[3]`=0x00, `flags`=4'b1100.
  - After AND: `rf[3]`=0x01, `flags`=4'b1000 (carry retained).
- Op 7 with rd=2 → `done`=`err`=1 one cycle after accept; `rf[2]` and `flags` unchanged; `alu_op` unchanged.
- `instr_valid` held high continuously with 3 ADDs → exactly one accept per 4 cycles; `instr_ready` low in ISSUE/CAPTURE/RETIRE.
- Assert `rst` during CAPTURE of SUB r1=r0−r0 (r1 preloaded 0x55) → no `done`; `rf` all 0; `instr_ready`=1 on the cycle after `rst` falls.
- NOT r1=~r0 with r0=0x0F → `alu_in2`=0x00, `alu_op`=11, `rf[1]`=0xF0, `flags`[1]=1, `flags`[2]=0.
